// File: rtl/saddr_replay_pkg.sv
// rtl/saddr_replay_pkg.sv - shared types and widths for the store MLB miss replay controller
package saddr_replay_pkg;

    localparam int ADDR_W   = 44;
    localparam int ATTR_W   = 4;
    localparam int PAGE_LSB = 13;
    localparam int PAGE_W   = ADDR_W - PAGE_LSB;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FIRE,
        DRAIN
    } replay_st_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [ATTR_W-1:0] attr;
    } replay_ent_t;

    function automatic logic [PAGE_W-1:0] page_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:PAGE_LSB];
    endfunction

endpackage

// File: rtl/saddr_miss_replay_if.sv
// rtl/saddr_miss_replay_if.sv - miss capture, page-walk and replay signals between addrcalc, walker and controller
interface saddr_miss_replay_if;
    import saddr_replay_pkg::*;

    logic              except;
    logic              miss_en;
    logic [ADDR_W-1:0] miss_addr;
    logic [ATTR_W-1:0] miss_attr;
    logic              issue_valid;
    logic              walk_req;
    logic [PAGE_W-1:0] walk_addr;
    logic              walk_ack;
    logic              walk_done;
    logic              bus_hold;
    logic              mex_en;
    logic [ADDR_W-1:0] mex_addr;
    logic [ATTR_W-1:0] mex_attr;
    logic              doStall;
    logic              miss_ovf;
    logic              busy;

    // Replay controller side
    modport master (
        input  except, miss_en, miss_addr, miss_attr, issue_valid, walk_ack, walk_done,
        output walk_req, walk_addr, bus_hold, mex_en, mex_addr, mex_attr, doStall, miss_ovf, busy
    );

    // addrcalc / walker side
    modport slave (
        output except, miss_en, miss_addr, miss_attr, issue_valid, walk_ack, walk_done,
        input  walk_req, walk_addr, bus_hold, mex_en, mex_addr, mex_attr, doStall, miss_ovf, busy
    );

endinterface

// File: rtl/saddr_replay_fifo.sv
// rtl/saddr_replay_fifo.sv - page-deduplicating miss queue with flush
module saddr_replay_fifo
    import saddr_replay_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_en,
    input  logic [ADDR_W-1:0]      push_addr,
    input  logic [ATTR_W-1:0]      push_attr,
    input  logic                   pop,
    output logic [ADDR_W-1:0]      head_addr,
    output logic [ATTR_W-1:0]      head_attr,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count_next,
    output logic                   drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    replay_ent_t     ent [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            match;
    logic            pop_ok;
    logic            accept;

    // The in-flight head stays valid until its replay pops it, so scanning
    // valid entries also merges against the page currently being walked.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid && (page_of(ent[i].addr) == page_of(push_addr))) begin
                match = 1'b1;
            end
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop_ok    = pop & ~empty;
    assign accept    = push_en & ~flush & ~match & (~full | pop_ok);
    assign drop      = push_en & ~flush & ~match & full & ~pop_ok;
    assign head_addr = ent[rd_ptr].addr;
    assign head_attr = ent[rd_ptr].attr;

    // Occupancy after this edge; also feeds the registered stall/busy outputs
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (accept && !pop_ok) begin
            count_next = count + CW'(1);
        end else if (!accept && pop_ok) begin
            count_next = count - CW'(1);
        end
    end

    // Storage and pointers; pop clears before push writes so a full push+pop reuses the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
        end else begin
            if (pop_ok) begin
                ent[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (accept) begin
                ent[wr_ptr] <= '{valid: 1'b1, addr: push_addr, attr: push_attr};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/saddr_miss_replay.sv
// rtl/saddr_miss_replay.sv - store MLB miss replay FSM, slot arbitration; optional SADDR_REPLAY_STARVE_EN
module saddr_miss_replay
    import saddr_replay_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef SADDR_REPLAY_STARVE_EN
    ,
    parameter int STARVE_MAX = 15
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    saddr_miss_replay_if.master  bus
);

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    replay_st_t        st;
    replay_st_t        st_n;
    logic              done_seen;
    logic              done_seen_n;
    logic              grant;
    logic              ready;
    logic              pop;
    logic              empty;
    logic              drop;
    logic [ADDR_W-1:0] head_addr;
    logic [ATTR_W-1:0] head_attr;
    logic [CW-1:0]     count_next;

    saddr_replay_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.except),
        .push_en    (bus.miss_en),
        .push_addr  (bus.miss_addr),
        .push_attr  (bus.miss_attr),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_attr  (head_attr),
        .empty      (empty),
        .count_next (count_next),
        .drop       (drop)
    );

    // Walk finished (now or earlier) and the replay only waits for the slot
    assign ready = ((st == WAIT) && (done_seen || bus.walk_done)) ||
                   ((st == REQ) && bus.walk_ack && bus.walk_done);

`ifdef SADDR_REPLAY_STARVE_EN
    logic [3:0] starve;

    assign grant = ~bus.issue_valid | (starve == 4'(STARVE_MAX));

    // Count cycles a ready replay has yielded to normal issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (bus.except || grant) begin
            starve <= '0;
        end else if (ready) begin
            starve <= starve + 4'd1;
        end
    end
`else
    logic issue_unused;

    // Replay always preempts normal issue, so issue_valid is not consulted
    assign grant        = 1'b1;
    assign issue_unused = bus.issue_valid;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            done_seen <= 1'b0;
        end else begin
            st        <= st_n;
            done_seen <= done_seen_n;
        end
    end

    // Next-state and pop decode for the head entry
    always_comb begin
        st_n        = st;
        done_seen_n = 1'b0;
        pop         = 1'b0;
        case (st)
            IDLE: begin
                if (!bus.except && !empty) st_n = REQ;
            end
            REQ: begin
                if (bus.except) begin
                    st_n = (bus.walk_ack && !bus.walk_done) ? DRAIN : IDLE;
                end else if (bus.walk_ack) begin
                    if (ready && grant) begin
                        st_n = HOLD;
                    end else begin
                        st_n        = WAIT;
                        done_seen_n = ready;
                    end
                end
            end
            WAIT: begin
                if (bus.except) begin
                    st_n = ready ? IDLE : DRAIN;
                end else if (ready) begin
                    if (grant) st_n = HOLD;
                    else       done_seen_n = 1'b1;
                end
            end
            HOLD: begin
                st_n = bus.except ? IDLE : FIRE;
            end
            FIRE: begin
                pop  = 1'b1;
                st_n = IDLE;
            end
            DRAIN: begin
                if (bus.walk_done) st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    // Registered outputs decoded from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.walk_req  <= 1'b0;
            bus.walk_addr <= '0;
            bus.bus_hold  <= 1'b0;
            bus.mex_en    <= 1'b0;
            bus.mex_addr  <= '0;
            bus.mex_attr  <= '0;
            bus.doStall   <= 1'b0;
            bus.miss_ovf  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.walk_req  <= (st_n == REQ);
            bus.walk_addr <= (st_n == REQ) ? page_of(head_addr) : '0;
            bus.bus_hold  <= (st_n == HOLD) || (st_n == FIRE);
            bus.mex_en    <= (st_n == FIRE);
            bus.mex_addr  <= (st_n == FIRE) ? head_addr : '0;
            bus.mex_attr  <= (st_n == FIRE) ? head_attr : '0;
            bus.doStall   <= (count_next >= STALL_LVL);
            bus.miss_ovf  <= drop;
            bus.busy      <= (count_next != '0) || (st_n != IDLE);
        end
    end

endmodule

// File: tb/tb_saddr_miss_replay.sv
// tb/tb_saddr_miss_replay.sv - scoreboard bench for saddr_miss_replay
module tb_saddr_miss_replay;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    saddr_miss_replay_if bus();

    saddr_miss_replay dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [43:0] addr;
        logic [3:0]  attr;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   replays = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Replays are compared against the scoreboard on the falling edge
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.mex_en) begin
            replays++;
            if (exp_q.size() == 0) begin
                check("replay_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("mex_addr", bus.mex_addr, e.addr);
                check("mex_attr", bus.mex_attr, e.attr);
            end
        end
    end

    task automatic drive_miss(input logic [43:0] a, input logic [3:0] at);
        bit   hit     = 0;
        logic exp_ovf = 1'b0;
        exp_t e;
        foreach (exp_q[i]) if (exp_q[i].addr[43:13] == a[43:13]) hit = 1;
        bus.miss_en   = 1'b1;
        bus.miss_addr = a;
        bus.miss_attr = at;
        tick();
        bus.miss_en = 1'b0;
        if (!hit) begin
            if (exp_q.size() < 4) begin
                e.addr = a;
                e.attr = at;
                exp_q.push_back(e);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        check("miss_ovf", bus.miss_ovf, exp_ovf);
    endtask

    task automatic wait_walk_req();
        int n = 0;
        while (!bus.walk_req && n < 50) begin
            tick();
            n++;
        end
        check("walk_req_wait", bus.walk_req, 1);
    endtask

    task automatic ack_pulse();
        bus.walk_ack = 1'b1;
        tick();
        bus.walk_ack = 1'b0;
    endtask

    task automatic serve_one();
        wait_walk_req();
        if (exp_q.size() > 0) check("walk_addr", bus.walk_addr, exp_q[0].addr[43:13]);
        ack_pulse();
        bus.walk_done = 1'b1;
        tick();
        bus.walk_done = 1'b0;
        check("hold_after_done", {bus.bus_hold, bus.mex_en}, 2'b10);
        tick();
        check("fire", {bus.bus_hold, bus.mex_en}, 2'b11);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          r0;
        int          n;
        bit          seen;
        logic [43:0] a;

        bus.except      = 1'b0;
        bus.miss_en     = 1'b0;
        bus.miss_addr   = '0;
        bus.miss_attr   = '0;
        bus.issue_valid = 1'b0;
        bus.walk_ack    = 1'b0;
        bus.walk_done   = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_flags", {bus.walk_req, bus.bus_hold, bus.mex_en, bus.doStall, bus.miss_ovf, bus.busy}, 6'b0);
        check("reset_mex_addr", bus.mex_addr, 0);
        rst = 1'b0;
        tick();

        // Single miss with latency checks
        drive_miss(44'h12345678ABC, 4'h5);
        check("single_walk_req_c1", bus.walk_req, 0);
        check("single_busy_c1", bus.busy, 1);
        tick();
        check("single_walk_req_c2", bus.walk_req, 1);
        check("single_walk_addr", bus.walk_addr, 31'h091A2B3C);
        r0 = replays;
        serve_one();
        check("single_replays", replays - r0, 1);
        check("single_busy_end", bus.busy, 0);

        // Same-page dedupe
        r0 = replays;
        drive_miss(44'h0000000_2010, 4'h1);
        drive_miss(44'h0000000_3FF0, 4'h2);
        check("dedupe_no_stall", bus.doStall, 0);
        serve_one();
        seen = 0;
        repeat (8) begin
            tick();
            seen |= bus.walk_req;
        end
        check("dedupe_single_walk", seen, 0);
        check("dedupe_replays", replays - r0, 1);
        check("dedupe_busy", bus.busy, 0);

        // Overflow with walker stalled
        r0 = replays;
        for (int i = 0; i < 5; i++) begin
            a = (44'(32'h100 + i) << 13) | 44'h018;
            drive_miss(a, 4'(i + 8));
            check($sformatf("dostall_push%0d", i + 1), bus.doStall, (i >= 2) ? 1 : 0);
        end
        tick();
        check("ovf_pulse_end", bus.miss_ovf, 0);
        check("walk_req_held", bus.walk_req, 1);
        repeat (4) serve_one();
        check("ovf_replays", replays - r0, 4);
        check("ovf_dostall_end", bus.doStall, 0);
        check("ovf_busy_end", bus.busy, 0);

        // Flush while a walk is outstanding, with a coinciding miss
        r0 = replays;
        drive_miss(44'h00000A0_0040, 4'h3);
        wait_walk_req();
        ack_pulse();
        bus.except    = 1'b1;
        bus.miss_en   = 1'b1;
        bus.miss_addr = 44'h00000A2_0000;
        bus.miss_attr = 4'h4;
        tick();
        bus.except  = 1'b0;
        bus.miss_en = 1'b0;
        exp_q.delete();
        check("drain_busy", bus.busy, 1);
        check("drain_no_walk_req", bus.walk_req, 0);
        repeat (3) tick();
        bus.walk_done = 1'b1;
        tick();
        bus.walk_done = 1'b0;
        check("drain_exit_busy", bus.busy, 0);
        seen = 0;
        repeat (10) begin
            tick();
            seen |= bus.walk_req | bus.mex_en | bus.busy;
        end
        check("drain_quiet", seen, 0);
        check("drain_replays", replays - r0, 0);

        // Replay against continuous normal issue
        drive_miss(44'h00000C0_1234, 4'h6);
        wait_walk_req();
        ack_pulse();
        bus.issue_valid = 1'b1;
        bus.walk_done   = 1'b1;
        tick();
        bus.walk_done = 1'b0;
        n = 1;
        while (!bus.bus_hold && n < 40) begin
            tick();
            n++;
        end
`ifdef SADDR_REPLAY_STARVE_EN
        check("hold_latency", n, 16);
`else
        check("hold_latency", n, 1);
`endif
        bus.issue_valid = 1'b0;
        tick();
        check("starve_fire", bus.mex_en, 1);
        tick();

        // Async reset during FIRE
        drive_miss(44'h0000100_0000, 4'h7);
        drive_miss(44'h0000102_0000, 4'h9);
        wait_walk_req();
        ack_pulse();
        bus.walk_done = 1'b1;
        tick();
        bus.walk_done = 1'b0;
        tick();
        check("rst_fire_mex_en", bus.mex_en, 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_flags", {bus.walk_req, bus.bus_hold, bus.mex_en, bus.doStall, bus.miss_ovf, bus.busy}, 6'b0);
        check("rst_async_mex_addr", bus.mex_addr, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            seen |= bus.walk_req | bus.busy;
        end
        check("rst_queue_empty", seen, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
